// File: rtl/gps_acq_search_seq.sv
// Acquisition search sequencer: walks a satellite list, centre-out Doppler bins and
// half-chip code phases, confirms detections M-of-N and re-searches after loss of lock.
module gps_acq_search_seq #(
  parameter int SAT_AW    = 3,
  parameter int DOP_BINS  = 21,
  parameter int DOP_STEP  = 93957,
  parameter int FREQ_W    = 30,
  parameter int CODE_POS  = 2046,
  parameter int CONFIRM_N = 4,
  parameter int CONFIRM_M = 3,
  parameter int LOSS_N    = 8,
  parameter int SETTLE    = 1,
  parameter int CONT      = 1
) (
  input  logic              mclk,
  input  logic              mclr,
  input  logic              start,
  input  logic              abort,
  input  logic [SAT_AW:0]   sat_count,
  input  logic              sat_we,
  input  logic [SAT_AW-1:0] sat_addr,
  input  logic [4:0]        sat_wdata,
  input  logic              dwell_done,
  input  logic              dwell_hit,
  input  logic              lock_ind,
  output logic [4:0]        code_sel,
  output logic [FREQ_W-1:0] carr_offset,
  output logic              code_slip,
  output logic              acq,
  output logic              busy,
  output logic              search_fail,
  output logic [4:0]        acq_bin
);

  localparam int NUM_SAT = 2 ** SAT_AW;
  localparam int CW = (CODE_POS > 1) ? $clog2(CODE_POS) : 1;
  localparam int HW = $clog2(CONFIRM_N + 1);
  localparam int MW = $clog2(LOSS_N + 1);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CW-1:0]     C_LAST = CW'(CODE_POS - 1);
  localparam logic [4:0]        B_LAST = 5'(DOP_BINS - 1);
  localparam logic [HW-1:0]     H_TGT  = HW'(CONFIRM_M);
  localparam logic [HW-1:0]     N_TGT  = HW'(CONFIRM_N);
  localparam logic [MW-1:0]     M_TGT  = MW'(LOSS_N);
  localparam logic [SW-1:0]     S_INIT = SW'(SETTLE);
  localparam logic [FREQ_W-1:0] STEP   = FREQ_W'(DOP_STEP);

  typedef enum logic [1:0] {IDLE, DWELL, CONFIRM, TRACK} state_t;

  state_t              state_q, state_d;
  logic [SAT_AW:0]     cnt_q, cnt_d;
  logic [SAT_AW:0]     p_q, p_d;
  logic [4:0]          b_q, b_d;
  logic [CW-1:0]       c_q, c_d;
  logic [SW-1:0]       s_q, s_d;
  logic [HW-1:0]       h_q, h_d;
  logic [HW-1:0]       n_q, n_d;
  logic [MW-1:0]       m_q, m_d;
  logic [FREQ_W-1:0]   mag_q, mag_d;
  logic                slip_q, slip_d;
  logic                fail_q, fail_d;
  logic                miss_adv;

  logic [4:0]          list_q [NUM_SAT];

  logic [4:0]          code_sel_q;
  logic [FREQ_W-1:0]   carr_offset_q;
  logic                code_slip_q, acq_q, busy_q, search_fail_q;
  logic [4:0]          acq_bin_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    c_d      = c_q;
    s_d      = s_q;
    h_d      = h_q;
    n_d      = n_q;
    m_d      = m_q;
    mag_d    = mag_q;
    slip_d   = 1'b0;
    fail_d   = 1'b0;
    miss_adv = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else if (state_q == IDLE && start && sat_count != '0) begin
      state_d = DWELL;
      cnt_d   = sat_count;
      p_d     = '0;
      b_d     = '0;
      c_d     = '0;
      s_d     = S_INIT;
      h_d     = '0;
      n_d     = '0;
      m_d     = '0;
      mag_d   = '0;
    end else if (dwell_done && s_q != '0) begin
      s_d = s_q - 1'b1;
    end else if (dwell_done) begin
      case (state_q)
        DWELL: begin
          if (dwell_hit) begin
            state_d = CONFIRM;
            h_d     = '0;
            n_d     = '0;
          end else begin
            miss_adv = 1'b1;
          end
        end
        CONFIRM: begin
          n_d = n_q + 1'b1;
          h_d = h_q + HW'(dwell_hit);
          if (h_d == H_TGT) begin
            state_d = TRACK;
            m_d     = '0;
          end else if (n_d == N_TGT) begin
            state_d  = DWELL;
            miss_adv = 1'b1;
          end
        end
        TRACK: begin
          if (lock_ind) begin
            m_d = '0;
          end else begin
            m_d = m_q + 1'b1;
            if (m_d == M_TGT) begin
              state_d = DWELL;
              b_d     = '0;
              c_d     = '0;
              s_d     = S_INIT;
              mag_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end

    // A miss steps the code phase; carries ripple into the bin and then the list pointer.
    if (miss_adv) begin
      slip_d = 1'b1;
      if (c_q == C_LAST) begin
        c_d = '0;
        s_d = S_INIT;
        if (b_q == B_LAST) begin
          b_d   = '0;
          mag_d = '0;
          if (p_q + 1'b1 == cnt_q) begin
            fail_d = 1'b1;
            p_d    = '0;
            if (CONT == 0) state_d = IDLE;
          end else begin
            p_d = p_q + 1'b1;
          end
        end else begin
          b_d = b_q + 1'b1;
          // Leaving an even bin moves to the next magnitude k.
          if (!b_q[0]) mag_d = mag_q + STEP;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mclk or posedge mclr) begin
    if (mclr) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      p_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      s_q           <= '0;
      h_q           <= '0;
      n_q           <= '0;
      m_q           <= '0;
      mag_q         <= '0;
      slip_q        <= 1'b0;
      fail_q        <= 1'b0;
      code_sel_q    <= 5'd1;
      carr_offset_q <= '0;
      code_slip_q   <= 1'b0;
      acq_q         <= 1'b0;
      busy_q        <= 1'b0;
      search_fail_q <= 1'b0;
      acq_bin_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p_q           <= p_d;
      b_q           <= b_d;
      c_q           <= c_d;
      s_q           <= s_d;
      h_q           <= h_d;
      n_q           <= n_d;
      m_q           <= m_d;
      mag_q         <= mag_d;
      slip_q        <= slip_d;
      fail_q        <= fail_d;
      // Output stage: one register behind the search state.
      code_sel_q    <= list_q[p_q[SAT_AW-1:0]];
      carr_offset_q <= b_q[0] ? mag_q : -mag_q;
      code_slip_q   <= slip_q;
      acq_q         <= (state_q == TRACK);
      busy_q        <= (state_q != IDLE);
      search_fail_q <= fail_q;
      acq_bin_q     <= b_q;
    end
  end

  always_ff @(posedge mclk or posedge mclr) begin
    if (mclr) begin
      for (int i = 0; i < NUM_SAT; i++) list_q[i] <= 5'(i + 1);
    end else if (sat_we && state_q == IDLE) begin
      list_q[sat_addr] <= sat_wdata;
    end
  end

  assign code_sel    = code_sel_q;
  assign carr_offset = carr_offset_q;
  assign code_slip   = code_slip_q;
  assign acq         = acq_q;
  assign busy        = busy_q;
  assign search_fail = search_fail_q;
  assign acq_bin     = acq_bin_q;

endmodule

// File: tb/tb_gps_acq_search_seq.sv
// Directed bench for gps_acq_search_seq: table-driven miss sweep plus hand sequences
// for confirmation, loss of lock, control races, CONT=0 and reset behaviour.
module tb_gps_acq_search_seq;

  localparam int SAT_AW = 3;
  localparam int FREQ_W = 30;

  logic              mclk = 1'b0;
  logic              mclr = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SAT_AW:0]   sat_count = '0;
  logic              sat_we = 1'b0;
  logic [SAT_AW-1:0] sat_addr = '0;
  logic [4:0]        sat_wdata = '0;
  logic              dwell_done = 1'b0;
  logic              dwell_hit = 1'b0;
  logic              lock_ind = 1'b0;

  logic [4:0]        code_sel, code_sel1;
  logic [FREQ_W-1:0] carr_offset, carr_offset1;
  logic              code_slip, code_slip1;
  logic              acq, acq1;
  logic              busy, busy1;
  logic              search_fail, search_fail1;
  logic [4:0]        acq_bin, acq_bin1;

  always #5 mclk = ~mclk;

  gps_acq_search_seq #(.CODE_POS(4), .DOP_BINS(5), .CONT(1)) dut (
    .mclk(mclk), .mclr(mclr), .start(start), .abort(abort), .sat_count(sat_count),
    .sat_we(sat_we), .sat_addr(sat_addr), .sat_wdata(sat_wdata),
    .dwell_done(dwell_done), .dwell_hit(dwell_hit), .lock_ind(lock_ind),
    .code_sel(code_sel), .carr_offset(carr_offset), .code_slip(code_slip), .acq(acq),
    .busy(busy), .search_fail(search_fail), .acq_bin(acq_bin)
  );

  gps_acq_search_seq #(.CODE_POS(4), .DOP_BINS(5), .CONT(0)) dut_nocont (
    .mclk(mclk), .mclr(mclr), .start(start), .abort(abort), .sat_count(sat_count),
    .sat_we(sat_we), .sat_addr(sat_addr), .sat_wdata(sat_wdata),
    .dwell_done(dwell_done), .dwell_hit(dwell_hit), .lock_ind(lock_ind),
    .code_sel(code_sel1), .carr_offset(carr_offset1), .code_slip(code_slip1), .acq(acq1),
    .busy(busy1), .search_fail(search_fail1), .acq_bin(acq_bin1)
  );

  typedef struct {
    logic              hit;
    logic              exp_slip;
    logic [FREQ_W-1:0] exp_off;
    logic [4:0]        exp_bin;
    logic              exp_fail;
  } vec_t;

  vec_t              sweep [25];
  logic [FREQ_W-1:0] offs [5];
  int                checks = 0;
  int                errors = 0;
  logic              slip_early, acq_early;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  // Dwell strobe sampled at edge t; returns 1ns after edge t+1 when the response is visible.
  task automatic dwell(input logic hit, input logic lock);
    dwell_done = 1'b1;
    dwell_hit  = hit;
    lock_ind   = lock;
    @(posedge mclk);
    #1;
    slip_early = code_slip;
    acq_early  = acq;
    dwell_done = 1'b0;
    dwell_hit  = 1'b0;
    lock_ind   = 1'b0;
    @(posedge mclk);
    #1;
  endtask

  task automatic pulse_start(input logic [SAT_AW:0] cnt);
    sat_count = cnt;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  initial begin
    offs[0] = '0;
    offs[1] = 30'd93957;
    offs[2] = -30'd93957;
    offs[3] = 30'd187914;
    offs[4] = -30'd187914;
    // Each bin: one settle dwell then four counted misses; the 4th miss moves the bin.
    for (int d = 0; d < 25; d++) begin
      int j, pos, ba;
      j   = d / 5;
      pos = d % 5;
      ba  = (pos == 4) ? (j + 1) % 5 : j;
      sweep[d].hit      = 1'b0;
      sweep[d].exp_slip = (pos != 0);
      sweep[d].exp_off  = offs[ba];
      sweep[d].exp_bin  = 5'(ba);
      sweep[d].exp_fail = (d == 24);
    end

    // Reset state
    cyc(3);
    chk("rst_code_sel", code_sel, 1);
    chk("rst_carr_offset", carr_offset, 0);
    chk("rst_acq", acq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_code_slip", code_slip, 0);
    chk("rst_search_fail", search_fail, 0);
    chk("rst_acq_bin", acq_bin, 0);
    mclr = 1'b0;
    cyc(1);

    // start with sat_count=0 is ignored
    pulse_start('0);
    cyc(1);
    chk("start_zero_busy", busy, 0);

    // List write in IDLE is visible through code_sel (p=0)
    sat_we = 1'b1; sat_addr = 3'd0; sat_wdata = 5'd9;
    cyc(1);
    sat_we = 1'b0;
    cyc(1);
    chk("idle_write_code_sel", code_sel, 9);
    sat_we = 1'b1; sat_wdata = 5'd1;
    cyc(1);
    sat_we = 1'b0;
    cyc(1);

    // start and abort together: abort wins
    sat_count = 4'd1; start = 1'b1; abort = 1'b1;
    cyc(1);
    start = 1'b0; abort = 1'b0;
    cyc(1);
    chk("start_abort_busy", busy, 0);

    // Normal start, then a list write while busy is dropped
    pulse_start(4'd1);
    sat_we = 1'b1; sat_addr = 3'd0; sat_wdata = 5'd9;
    cyc(1);
    sat_we = 1'b0;
    cyc(1);
    chk("start_busy", busy, 1);
    chk("start_busy_nocont", busy1, 1);
    chk("busy_write_dropped", code_sel, 1);
    chk("start_offset", carr_offset, 0);

    // Full miss sweep over one satellite
    for (int i = 0; i < 25; i++) begin
      dwell(sweep[i].hit, 1'b0);
      chk($sformatf("sweep%0d_slip", i), code_slip, sweep[i].exp_slip);
      chk($sformatf("sweep%0d_offset", i), carr_offset, sweep[i].exp_off);
      chk($sformatf("sweep%0d_bin", i), acq_bin, sweep[i].exp_bin);
      chk($sformatf("sweep%0d_fail", i), search_fail, sweep[i].exp_fail);
    end
    chk("nocont_fail", search_fail1, 1);
    chk("nocont_busy", busy1, 0);
    chk("cont_busy", busy, 1);
    cyc(1);
    chk("fail_one_cycle", search_fail, 0);
    chk("slip_one_cycle", code_slip, 0);
    dwell(1'b0, 1'b0);
    chk("restart_settle_slip", code_slip, 0);
    chk("restart_offset", carr_offset, 0);
    chk("restart_bin", acq_bin, 0);

    // Move to bin 1, then confirmation pass (hit, then hit/miss/hit/hit)
    repeat (4) dwell(1'b0, 1'b0);
    chk("bin1_offset", carr_offset, 30'd93957);
    chk("bin1_bin", acq_bin, 1);
    dwell(1'b0, 1'b0);
    dwell(1'b1, 1'b0);
    chk("cfm_entry_slip", code_slip, 0);
    dwell(1'b1, 1'b0);
    chk("cfm1_slip", code_slip, 0);
    chk("cfm1_acq", acq, 0);
    dwell(1'b0, 1'b0);
    chk("cfm2_slip", code_slip, 0);
    chk("cfm2_acq", acq, 0);
    dwell(1'b1, 1'b0);
    chk("cfm3_slip", code_slip, 0);
    chk("cfm3_acq", acq, 0);
    dwell(1'b1, 1'b0);
    chk("cfm4_acq_latency", acq_early, 0);
    chk("cfm4_acq", acq, 1);
    chk("cfm4_slip", code_slip, 0);

    // Loss of lock: 7 misses, 1 lock, 8 misses
    for (int i = 0; i < 7; i++) begin
      dwell(1'b0, 1'b0);
      chk($sformatf("trk_a%0d_acq", i), acq, 1);
    end
    chk("trk_hold_offset", carr_offset, 30'd93957);
    chk("trk_hold_code_sel", code_sel, 1);
    dwell(1'b0, 1'b1);
    chk("trk_lock_acq", acq, 1);
    for (int i = 0; i < 7; i++) begin
      dwell(1'b0, 1'b0);
      chk($sformatf("trk_b%0d_acq", i), acq, 1);
      chk($sformatf("trk_b%0d_slip", i), code_slip, 0);
    end
    dwell(1'b0, 1'b0);
    chk("loss_acq", acq, 0);
    chk("loss_code_sel", code_sel, 1);
    chk("loss_offset", carr_offset, 0);
    chk("loss_bin", acq_bin, 0);
    chk("loss_busy", busy, 1);

    // Confirmation fail: 2 of 4 hits
    dwell(1'b0, 1'b0);
    dwell(1'b1, 1'b0);
    dwell(1'b1, 1'b0);
    chk("cfail1_slip", code_slip, 0);
    dwell(1'b0, 1'b0);
    chk("cfail2_slip", code_slip, 0);
    dwell(1'b1, 1'b0);
    chk("cfail3_slip", code_slip, 0);
    dwell(1'b0, 1'b0);
    chk("cfail4_slip", code_slip, 1);
    chk("cfail4_acq", acq, 0);
    dwell(1'b0, 1'b0);
    chk("cfail_c2_bin", acq_bin, 0);
    dwell(1'b0, 1'b0);
    chk("cfail_c3_bin", acq_bin, 0);
    dwell(1'b0, 1'b0);
    chk("cfail_wrap_bin", acq_bin, 1);
    chk("cfail_wrap_slip", code_slip, 1);

    // Abort holds code_sel and carr_offset
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(1);
    chk("abort_busy", busy, 0);
    chk("abort_acq", acq, 0);
    chk("abort_offset_hold", carr_offset, 30'd93957);

    // Overwrite list[3], walk to satellite 3, then reset mid-DWELL
    sat_we = 1'b1; sat_addr = 3'd3; sat_wdata = 5'd20;
    cyc(1);
    sat_we = 1'b0;
    pulse_start(4'd4);
    repeat (75) dwell(1'b0, 1'b0);
    chk("sat3_code_sel", code_sel, 20);
    repeat (6) dwell(1'b0, 1'b0);
    chk("sat3_bin1_offset", carr_offset, 30'd93957);
    chk("sat3_busy", busy, 1);
    mclr = 1'b1;
    #1;
    chk("arst_code_sel", code_sel, 1);
    chk("arst_offset", carr_offset, 0);
    chk("arst_bin", acq_bin, 0);
    chk("arst_busy", busy, 0);
    chk("arst_acq", acq, 0);
    chk("arst_slip", code_slip, 0);
    chk("arst_fail", search_fail, 0);
    cyc(2);
    mclr = 1'b0;
    pulse_start(4'd4);
    repeat (75) dwell(1'b0, 1'b0);
    chk("list_reinit_code_sel", code_sel, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_acq_search_seq.md
# gps_acq_search_seq

Parametrised acquisition search sequencer for the GPS/IRNSS baseband channel. It walks a programmable list of satellite IDs. For each satellite it searches Doppler bins in centre-out order, and for each bin it searches code phases in half-chip steps. Detections are confirmed with an M-of-N test, and after lock is lost the block re-enters search on the same satellite. It sits between the threshold block (per-dwell hit), the clock generator (dwell strobe, carrier offset) and the code control logic (PRN select, code slip).

## Interface
Parameters:
- SAT_AW, 3: satellite list address width; list depth NUM_SAT = 2**SAT_AW
- DOP_BINS, 21: Doppler bins, odd, ≥1
- DOP_STEP, 93957: carrier NCO word per bin (500 Hz for a 30-bit NCO)
- FREQ_W, 30: carrier offset width
- CODE_POS, 2046: half-chip code positions per bin
- CONFIRM_N, 4: confirmation dwells
- CONFIRM_M, 3: hits required among the CONFIRM_N dwells
- LOSS_N, 8: consecutive tracking misses that declare loss of lock
- SETTLE, 1: dwells discarded after any satellite or bin change
- CONT, 1: 1 = restart from the list head after a full-list failure; 0 = go to IDLE

Ports (clock and reset first):
- mclk  in  1  master clock
- mclr  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a search
- abort  in  1  one-cycle pulse; returns the block to IDLE
- sat_count  in  SAT_AW+1  number of list entries to search; latched on start
- sat_we  in  1  list write strobe
- sat_addr  in  SAT_AW  list write address
- sat_wdata  in  5  satellite ID to write
- dwell_done  in  1  one-cycle strobe at the end of each integration dwell
- dwell_hit  in  1  threshold result; valid only while dwell_done=1
- lock_ind  in  1  tracking lock indicator; sampled on dwell_done in TRACK
- code_sel  out  5  PRN select driven to code control
- carr_offset  out  FREQ_W  two's-complement Doppler offset
- code_slip  out  1  one-cycle pulse: retard replica by one half chip
- acq  out  1  level; high while in TRACK
- busy  out  1  high in any state other than IDLE
- search_fail  out  1  one-cycle pulse when the whole list is exhausted
- acq_bin  out  5  index of the current Doppler bin

## Operation
- States: IDLE, DWELL, CONFIRM, TRACK.
- IDLE:
  - start with sat_count≠0 latches sat_count; sets list pointer p=0, bin b=0, code counter c=0, settle counter s=SETTLE; goes to DWELL.
  - start with sat_count=0 is ignored.
- Settle: any dwell_done with s>0 decrements s and is otherwise ignored, in every state.
- DWELL, on dwell_done:
  - hit: go to CONFIRM with hit count h=0 and dwell count n=0.
  - miss: pulse code_slip and increment c.
  - When c reaches CODE_POS-1 and another miss occurs: c←0, advance b, s←SETTLE.
  - When b wraps past DOP_BINS-1: b←0 and advance p.
  - When p reaches the latched sat_count: pulse search_fail and set p←0. With CONT=1 the search continues; with CONT=0 the block goes to IDLE.
- Doppler order is centre-out:
  - b=0 gives offset 0.
  - Odd b gives offset +k·DOP_STEP and even b>0 gives −k·DOP_STEP, with k=(b+1)/2.
  - The magnitude is kept in an accumulator (add DOP_STEP whenever k increments). No multiplier.
  - carr_offset wraps modulo 2^FREQ_W.
- CONFIRM, on dwell_done: n++, and h++ on a hit. No code slip is issued.
  - If h reaches CONFIRM_M: go to TRACK and set acq=1 (early exit).
  - Else if n reaches CONFIRM_N: treat it as a DWELL miss (slip, advance c/b/p as above) and return to DWELL.
- TRACK, on dwell_done:
  - lock_ind=1 clears the miss counter m.
  - lock_ind=0 increments m. When m reaches LOSS_N: acq←0, b←0, c←0, s←SETTLE, same p, go to DWELL.
  - code_sel and carr_offset are held while in TRACK.
- code_sel always equals list[p].
- The list is writable only in IDLE. Writes while busy are dropped.
- abort from any state: go to IDLE with acq=0. code_sel and carr_offset hold their values.
- abort and start in the same cycle: abort wins.
- start while busy is ignored.

## Timing
- All outputs are registered.
- The response to a dwell_done sampled at edge t is visible after edge t+1: code_slip pulse, new carr_offset, new code_sel, acq change.
- code_slip and search_fail are exactly one cycle wide.
- dwell_done is assumed to be at least 2 cycles apart.
- Reset (asynchronous, immediate):
  - state=IDLE
  - list[i]=i+1
  - code_sel=1, carr_offset=0, acq_bin=0
  - acq=0, busy=0, code_slip=0, search_fail=0
  - all counters 0
- Reset asserted mid-search forces the reset values immediately. The list contents are reinitialised.

## Test plan
- Reset checks: assert mclr mid-DWELL → all outputs at their reset values in the same cycle; list[3] reads back as 4 through code_sel.
- Miss sweep: defaults with CODE_POS=4, DOP_BINS=5, sat_count=1, all misses → code_slip pulses on each non-settle miss. carr_offset sequence is 0, +93957, −93957, +187914, −187914. search_fail pulses after 25 dwells (5 settle + 20 counted), then the sequence restarts at 0.
- Confirmation pass: a hit then hits on 3 of 4 confirm dwells → acq=1 one cycle after the 3rd hit; no code_slip during CONFIRM.
- Confirmation fail: 2 of 4 confirm hits → single code_slip, return to DWELL, c incremented.
- Loss of lock: in TRACK, 7 misses, 1 hit, 8 misses → acq drops only after the final 8th consecutive miss; code_sel unchanged; carr_offset returns to 0.
- Control races: start+abort in the same cycle → stays IDLE. sat_we while busy → list unchanged. CONT=0 with full-list failure → search_fail pulse, then busy=0.
